// File: rtl/conv_result_writer.sv
// Conv result writer: captures one packed multi-kernel pixel word and bursts it
// into a kernel-major feature-map RAM, one 32-bit word per cycle.
module conv_result_writer #(
    parameter int KERNEL_NUM     = 6,
    parameter int PIXELS_PER_MAP = 36,
    parameter int ADDR_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [32*KERNEL_NUM-1:0] i_pixel_bus,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [ADDR_WIDTH-1:0]    ram_addr,
    output logic [31:0]              ram_din,
    output logic                     ram_we,
    output logic                     o_done
);

    localparam int BUS_W = 32 * KERNEL_NUM;
    localparam int KW    = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
    localparam int PW    = (PIXELS_PER_MAP > 1) ? $clog2(PIXELS_PER_MAP) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(KERNEL_NUM - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PIXELS_PER_MAP - 1);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

    state_t            state;
    logic [KW-1:0]     k_idx;
    logic [PW-1:0]     pix_idx;
    logic [BUS_W-1:0]  shadow;
    logic              abort_pend;
    logic              abort_now;
    logic [ADDR_WIDTH-1:0] wr_addr;

    always_comb begin
        wr_addr   = ADDR_WIDTH'(int'(k_idx) * PIXELS_PER_MAP + int'(pix_idx));
        abort_now = abort_pend | ~enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            o_ready    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            o_done     <= 1'b0;
            pix_idx    <= '0;
            k_idx      <= '0;
            shadow     <= '0;
            abort_pend <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_ready <= 1'b0;
                    pix_idx <= '0;
                    if (enable) state <= WAIT;
                end
                WAIT: begin
                    if (!enable) begin
                        state   <= IDLE;
                        o_ready <= 1'b0;
                        pix_idx <= '0;
                    end else if (i_valid && o_ready) begin
                        shadow     <= i_pixel_bus;
                        k_idx      <= '0;
                        abort_pend <= 1'b0;
                        o_ready    <= 1'b0;
                        state      <= WRITE;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    // Shadow shifts up one word per write so kernel 0 leaves first.
                    ram_we     <= 1'b1;
                    ram_addr   <= wr_addr;
                    ram_din    <= shadow[BUS_W-1 -: 32];
                    shadow     <= shadow << 32;
                    k_idx      <= k_idx + KW'(1);
                    abort_pend <= abort_now;
                    if (k_idx == K_LAST) begin
                        k_idx <= '0;
                        if (abort_now) begin
                            state   <= IDLE;
                            pix_idx <= '0;
                        end else if (pix_idx == P_LAST) begin
                            state <= DONE;
                        end else begin
                            pix_idx <= pix_idx + PW'(1);
                            state   <= WAIT;
                        end
                    end
                end
                DONE: begin
                    o_done  <= 1'b1;
                    o_ready <= 1'b0;
                    pix_idx <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
